ship_board: RTL and testbench
=============================

SHIP_BOARD -- requirements
Module: ship_board

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 place_en  input  1  high = placement phase; shot requests ignored.
REQ-004 pick_ship  input  1  level request from game control; its rising edge toggles one cell.
REQ-005 mouse_position  input  8  cell address: [7:4] = row y, [3:0] = column x.
REQ-006 shot_valid  input  1  single-cycle pulse; incoming opponent shot present.
REQ-007 shot_addr  input  8  opponent shot address, same encoding as mouse_position.
REQ-008 result_ack  input  1  consumer accepted shot_result.
REQ-009 ship_count  output  4  number of occupied cells, 0..11.
REQ-010 shot_result  output  2  code: 00 none, 01 miss, 10 hit, 11 invalid/repeat.
REQ-011 result_valid  output  1  shot_result valid; held until result_ack.
REQ-012 shot_busy  output  1  high whenever the shot FSM is not in IDLE.
REQ-013 all_sunk  output  1  high when hit_count == 11; sticky until reset.

Function
REQ-014 Board state: two 100-bit vectors; ship[i] and shot[i], with i = y*10 + x on 7 bits.
REQ-015 A cell address is valid only when x <= 9 and y <= 9; an invalid address never modifies state.
REQ-016 Rising-edge detection of pick_ship: registered previous value; action occurs in the cycle after the edge.
REQ-017 On the edge with place_en=1, valid address, and ship[i]=0: set the cell only if ship_count < 11, then ship_count +1.
REQ-018 On the edge with place_en=1, valid address, and ship[i]=1: clear the cell and decrement ship_count.
REQ-019 With ship_count == 11, an add request is ignored; a remove request is still honoured.
REQ-020 Placement is ignored while place_en=0; the ship vector is frozen.
REQ-021 Shot FSM states and transitions:
- IDLE -> CHECK on shot_valid & !place_en; shot_addr is latched.
- CHECK -> RESP after exactly 1 cycle.
- RESP -> IDLE on result_ack.
REQ-022 Result is evaluated in CHECK in this priority order:
- invalid address -> 11;
- shot[i]=1 -> 11;
- ship[i]=1 -> 10, set shot[i], hit_count +1;
- otherwise -> 01, set shot[i].
REQ-023 In RESP: result_valid=1 and shot_result is stable; latency from shot_valid to result_valid is 2 cycles.
REQ-024 In IDLE and CHECK: shot_result=00 and result_valid=0.
REQ-025 A result_ack asserted in the same cycle RESP is entered is honoured, giving a 1-cycle RESP.
REQ-026 shot_valid arriving while shot_busy=1, or while place_en=1, is dropped; no queueing.
REQ-027 hit_count is 4 bits and saturates at 11; all_sunk is set combinationally from hit_count == 11 and is registered.
REQ-028 A pick_ship edge and a shot_valid in the same cycle are mutually exclusive by the place_en gating; no arbitration is needed.

Reset
REQ-029 On rst, every state element clears asynchronously: ship, shot, ship_count=0, hit_count=0, FSM=IDLE, shot_result=00, result_valid=0, shot_busy=0, all_sunk=0, and the edge-detect register.
REQ-030 rst asserted mid-transaction abandons the pending result; no result_valid is produced after reset release.

Structure
REQ-031 The shared vga_pkg-style game package holds:
- BOARD_DIM=10 and SHIP_TOTAL=11;
- a result-code typedef (RES_NONE, RES_MISS, RES_HIT, RES_INVALID);
- the shot FSM state typedef.
REQ-032 One sub-module, edge_rise (1-bit registered rising-edge detector, clk/rst), is instantiated for pick_ship.
REQ-033 The cell-index computation (y*10 + x) and the range check are shared combinational logic used by both the placement path and the shot path.

Verification
REQ-034 Placement toggle: place_en=1; pulse pick_ship at 0x23, then at 0x45, then at 0x23 again -> ship_count sequence 1, 2, 1; ship[23]=0 and ship[45]=1.
REQ-035 Placement saturation: 12 distinct valid pick_ship edges -> ship_count stops at 11; the 12th cell stays empty; a removal afterwards gives 10.
REQ-036 Shot hit/miss/repeat: place a ship at 0x45, place_en=0.
- shot 0x45 -> 10;
- shot 0x45 again -> 11;
- shot 0x00 -> 01.
- Each result appears 2 cycles after shot_valid and is held until result_ack.
REQ-037 Invalid address and busy drop:
- shot 0xA3 -> 11 with no state change;
- a second shot_valid during RESP is dropped and no extra result appears.
REQ-038 Sink all and reset: 11 ships placed, 11 distinct hits -> all_sunk=1 after the 11th CHECK; assert rst mid-RESP -> all outputs return to 0 immediately.

Source files
------------

// File: rtl/ship_board_pkg.sv
// Shared game definitions for the ship board: board geometry, result codes,
// shot FSM states and the cell addressing helpers.
package ship_board_pkg;

  localparam logic [3:0] BOARD_DIM  = 4'd10;
  localparam logic [3:0] SHIP_TOTAL = 4'd11;

  typedef enum logic [1:0] {
    RES_NONE    = 2'b00,
    RES_MISS    = 2'b01,
    RES_HIT     = 2'b10,
    RES_INVALID = 2'b11
  } result_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_RESP
  } shot_state_e;

  // Address layout: [7:4] = row y, [3:0] = column x.
  function automatic logic cell_in_range(input logic [7:0] addr);
    return (addr[3:0] < BOARD_DIM) && (addr[7:4] < BOARD_DIM);
  endfunction

  function automatic logic [6:0] cell_index(input logic [7:0] addr);
    return 7'(addr[7:4]) * 7'(BOARD_DIM) + 7'(addr[3:0]);
  endfunction

endpackage

// File: rtl/ship_board_edge_rise.sv
// One-bit rising-edge detector: previous value is registered, rise is
// high during the first cycle the input is seen high.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/ship_board.sv
// Battleship board: ship placement by pick_ship edges and a three-state
// shot evaluator reporting miss / hit / invalid-or-repeat with handshake.
module ship_board
  import ship_board_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       place_en,
  input  logic       pick_ship,
  input  logic [7:0] mouse_position,
  input  logic       shot_valid,
  input  logic [7:0] shot_addr,
  input  logic       result_ack,
  output logic [3:0] ship_count,
  output logic [1:0] shot_result,
  output logic       result_valid,
  output logic       shot_busy,
  output logic       all_sunk
);

  shot_state_e state, state_next;
  logic [99:0] ship;
  logic [99:0] shot;
  logic [3:0]  hit_count, hit_next;
  logic [7:0]  shot_addr_q;
  result_e     res_q, res_d;
  logic        pick_rise;
  logic [7:0]  cell_addr;
  logic [6:0]  cell_idx;
  logic        cell_ok;
  logic        place_req;

  edge_rise u_pick_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (pick_ship),
    .rise (pick_rise)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (shot_valid && !place_en) state_next = S_CHECK;
      S_CHECK: state_next = S_RESP;
      S_RESP:  if (result_ack) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    // One index/range unit serves both paths; CHECK owns it for its single cycle.
    cell_addr = (state == S_CHECK) ? shot_addr_q : mouse_position;
    cell_ok   = cell_in_range(cell_addr);
    cell_idx  = cell_index(cell_addr);

    if (!cell_ok)            res_d = RES_INVALID;
    else if (shot[cell_idx]) res_d = RES_INVALID;
    else if (ship[cell_idx]) res_d = RES_HIT;
    else                     res_d = RES_MISS;

    hit_next = hit_count;
    if (state == S_CHECK && res_d == RES_HIT && hit_count < SHIP_TOTAL)
      hit_next = hit_count + 4'd1;

    place_req = place_en && pick_rise && cell_ok && (state != S_CHECK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ship        <= '0;
      shot        <= '0;
      ship_count  <= '0;
      hit_count   <= '0;
      shot_addr_q <= '0;
      res_q       <= RES_NONE;
      all_sunk    <= 1'b0;
    end else begin
      state     <= state_next;
      hit_count <= hit_next;
      all_sunk  <= all_sunk | (hit_next == SHIP_TOTAL);

      if (state == S_IDLE && shot_valid && !place_en)
        shot_addr_q <= shot_addr;

      if (state == S_CHECK) begin
        res_q <= res_d;
        if (res_d == RES_HIT || res_d == RES_MISS)
          shot[cell_idx] <= 1'b1;
      end

      if (place_req) begin
        if (ship[cell_idx]) begin
          ship[cell_idx] <= 1'b0;
          ship_count     <= ship_count - 4'd1;
        end else if (ship_count < SHIP_TOTAL) begin
          ship[cell_idx] <= 1'b1;
          ship_count     <= ship_count + 4'd1;
        end
      end
    end
  end

  assign shot_busy    = (state != S_IDLE);
  assign result_valid = (state == S_RESP);
  assign shot_result  = (state == S_RESP) ? res_q : RES_NONE;

endmodule

// File: tb/tb_ship_board.sv
// Self-checking bench for ship_board: directed tables, multi-cycle corner
// sequences and randomized traffic against a cell-array reference model.
module tb_ship_board;

  logic       clk;
  logic       rst;
  logic       place_en;
  logic       pick_ship;
  logic [7:0] mouse_position;
  logic       shot_valid;
  logic [7:0] shot_addr;
  logic       result_ack;
  logic [3:0] ship_count;
  logic [1:0] shot_result;
  logic       result_valid;
  logic       shot_busy;
  logic       all_sunk;

  ship_board dut (
    .clk            (clk),
    .rst            (rst),
    .place_en       (place_en),
    .pick_ship      (pick_ship),
    .mouse_position (mouse_position),
    .shot_valid     (shot_valid),
    .shot_addr      (shot_addr),
    .result_ack     (result_ack),
    .ship_count     (ship_count),
    .shot_result    (shot_result),
    .result_valid   (result_valid),
    .shot_busy      (shot_busy),
    .all_sunk       (all_sunk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  // Reference model: plain per-cell flags and counters.
  bit ship_m [100];
  bit shot_m [100];
  int ships_m;
  int hits_m;

  typedef struct {
    logic       pe;
    logic [7:0] addr;
    int         exp_cnt;
  } place_vec_t;

  typedef struct {
    logic [7:0]  addr;
    int unsigned hold;
    logic [1:0]  exp;
  } shot_vec_t;

  place_vec_t pv [6];
  shot_vec_t  sv [7];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit addr_ok(input logic [7:0] a);
    return (int'(a[3:0]) <= 9) && (int'(a[7:4]) <= 9);
  endfunction

  function automatic int addr_idx(input logic [7:0] a);
    return int'(a[7:4]) * 10 + int'(a[3:0]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 100; i++) begin
      ship_m[i] = 0;
      shot_m[i] = 0;
    end
    ships_m = 0;
    hits_m  = 0;
  endtask

  task automatic model_shot(input logic [7:0] a, output logic [1:0] exp);
    int i;
    if (!addr_ok(a)) exp = 2'b11;
    else begin
      i = addr_idx(a);
      if (shot_m[i]) exp = 2'b11;
      else begin
        shot_m[i] = 1;
        if (ship_m[i]) begin
          exp = 2'b10;
          if (hits_m < 11) hits_m++;
        end else exp = 2'b01;
      end
    end
  endtask

  task automatic pick(input logic [7:0] a);
    int i;
    if (place_en && addr_ok(a)) begin
      i = addr_idx(a);
      if (ship_m[i]) begin
        ship_m[i] = 0;
        ships_m--;
      end else if (ships_m < 11) begin
        ship_m[i] = 1;
        ships_m++;
      end
    end
    mouse_position = a;
    pick_ship = 1'b1;
    tick();
    pick_ship = 1'b0;
    tick();
    check("ship_count", int'(ship_count), ships_m);
  endtask

  task automatic shoot(input logic [7:0] a, input int unsigned hold, input bit early,
                       input bit drop, output logic [1:0] got);
    logic [1:0] exp;
    model_shot(a, exp);
    shot_addr  = a;
    shot_valid = 1'b1;
    tick();
    check("check_busy", int'(shot_busy), 1);
    check("check_rv", int'(result_valid), 0);
    check("check_res", int'(shot_result), 0);
    shot_valid = 1'b0;
    shot_addr  = 8'($urandom);
    if (early) result_ack = 1'b1;
    tick();
    check("resp_rv", int'(result_valid), 1);
    check("resp_res", int'(shot_result), int'(exp));
    check("resp_sunk", int'(all_sunk), (hits_m == 11) ? 1 : 0);
    got = shot_result;
    if (!early) begin
      for (int k = 0; k < int'(hold); k++) begin
        if (drop && k == 0) begin
          shot_valid = 1'b1;
          shot_addr  = a ^ 8'h01;
        end
        tick();
        shot_valid = 1'b0;
        check("hold_rv", int'(result_valid), 1);
        check("hold_res", int'(shot_result), int'(exp));
      end
      result_ack = 1'b1;
    end
    tick();
    result_ack = 1'b0;
    check("ack_busy", int'(shot_busy), 0);
    check("ack_rv", int'(result_valid), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    place_en = 1'b0;
    pick_ship = 1'b0;
    shot_valid = 1'b0;
    result_ack = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_count"}, int'(ship_count), 0);
    check({tag, "_res"}, int'(shot_result), 0);
    check({tag, "_rv"}, int'(result_valid), 0);
    check({tag, "_busy"}, int'(shot_busy), 0);
    check({tag, "_sunk"}, int'(all_sunk), 0);
  endtask

  initial begin
    logic [1:0] got;
    logic [7:0] a;
    int guard;

    mouse_position = '0;
    shot_addr = '0;
    rst = 1'b1;
    place_en = 1'b0;
    pick_ship = 1'b0;
    shot_valid = 1'b0;
    result_ack = 1'b0;
    model_reset();
    #3;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Placement toggle, invalid addresses and frozen placement.
    pv[0] = '{1'b1, 8'h23, 1};
    pv[1] = '{1'b1, 8'h45, 2};
    pv[2] = '{1'b1, 8'h23, 1};
    pv[3] = '{1'b1, 8'hA3, 1};
    pv[4] = '{1'b0, 8'h67, 1};
    pv[5] = '{1'b1, 8'h5C, 1};
    for (int n = 0; n < 6; n++) begin
      place_en = pv[n].pe;
      pick(pv[n].addr);
      check("place_table", int'(ship_count), pv[n].exp_cnt);
    end

    // Shot while still placing is dropped.
    place_en = 1'b1;
    shot_addr = 8'h45;
    shot_valid = 1'b1;
    tick();
    shot_valid = 1'b0;
    check("place_drop_busy", int'(shot_busy), 0);
    tick();
    check("place_drop_rv", int'(result_valid), 0);
    place_en = 1'b0;

    // Only 0x45 holds a ship now.
    sv[0] = '{8'h45, 2, 2'b10};
    sv[1] = '{8'h45, 0, 2'b11};
    sv[2] = '{8'h00, 1, 2'b01};
    sv[3] = '{8'hA3, 0, 2'b11};
    sv[4] = '{8'h23, 0, 2'b01};
    sv[5] = '{8'h3A, 1, 2'b11};
    sv[6] = '{8'h99, 3, 2'b01};
    for (int n = 0; n < 7; n++) begin
      shoot(sv[n].addr, sv[n].hold, 1'b0, 1'b0, got);
      check("shot_table", int'(got), int'(sv[n].exp));
    end

    // Second shot during RESP is dropped; its cell must still be unshot.
    shoot(8'h11, 2, 1'b0, 1'b1, got);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("drop_idle_busy", int'(shot_busy), 0);
      check("drop_idle_rv", int'(result_valid), 0);
    end
    shoot(8'h10, 0, 1'b0, 1'b0, got);
    check("drop_not_applied", int'(got), 1);

    // Ack already high when RESP is entered.
    shoot(8'h54, 0, 1'b1, 1'b0, got);
    check("early_ack_res", int'(got), 1);

    // Saturation at 11 ships.
    do_reset();
    place_en = 1'b1;
    for (int j = 0; j < 12; j++) begin
      a = {4'(j / 4), 4'(j % 4)};
      pick(a);
      check("sat_count", int'(ship_count), (j < 11) ? j + 1 : 11);
    end
    pick(8'h00);
    check("sat_remove", int'(ship_count), 10);
    place_en = 1'b0;
    shoot(8'h23, 0, 1'b0, 1'b0, got);
    check("sat_12th_empty", int'(got), 1);

    // Randomized placement and shots, then sink every ship.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      place_en = ($urandom_range(0, 7) != 0);
      a = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
      pick(a);
    end
    place_en = 1'b1;
    guard = 0;
    while (ships_m < 11 && guard < 2000) begin
      a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if (!ship_m[addr_idx(a)]) pick(a);
      guard++;
    end
    check("fill_count", int'(ship_count), 11);
    place_en = 1'b0;
    for (int n = 0; n < 30; n++) begin
      a = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
      shoot(a, $urandom_range(1, 2), ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), got);
    end
    for (int i = 0; i < 100; i++) begin
      if (ship_m[i] && !shot_m[i]) begin
        a = {4'(i / 10), 4'(i % 10)};
        shoot(a, 0, 1'b0, 1'b0, got);
      end
    end
    check("all_sunk_set", int'(all_sunk), 1);
    shoot(8'h99, 1, 1'b0, 1'b0, got);
    check("all_sunk_sticky", int'(all_sunk), 1);

    // Reset in the middle of RESP.
    shot_addr = 8'h98;
    shot_valid = 1'b1;
    tick();
    shot_valid = 1'b0;
    tick();
    check("pre_rst_rv", int'(result_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_rv", int'(result_valid), 0);
      check("post_rst_busy", int'(shot_busy), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
